// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - command encodings and default address map for the MMIO fabric
package mmio_pkg;

  typedef enum logic [1:0] {
    MNONE    = 2'b00,
    MREAD    = 2'b01,
    MWRITE   = 2'b10,
    MILLEGAL = 2'b11
  } mem_cmd_e;

  localparam logic [8:0] DEF_IO_BASE  = 9'h100;
  localparam int         DEF_IN_OFS   = 'h40;
  localparam int         DEF_EDGE_OFS = 'h80;

  // Addresses of the single LED / switch in the fixed decode this fabric replaces
  localparam logic [8:0] LEDADDR = 9'h100;
  localparam logic [8:0] SWADDR  = 9'h140;

endpackage

// File: rtl/mmio_in_sync.sv
// rtl/mmio_in_sync.sv - two-flop input synchroniser with change detect against the previous synchronised sample
module mmio_in_sync #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              change
);

  logic [DATA_W-1:0] sync1;
  logic [DATA_W-1:0] sync2;
  logic [DATA_W-1:0] prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign dout   = sync2;
  assign change = (sync2 != prev);

endmodule

// File: rtl/mmio_bus.sv
// rtl/mmio_bus.sv - CPU memory-port decode between RAM, output registers, synchronised inputs and change flags
module mmio_bus import mmio_pkg::*; #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter int                N_OUT    = 2,
  parameter int                N_IN     = 2,
  parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(DEF_IO_BASE),
  parameter int                IN_OFS   = DEF_IN_OFS,
  parameter int                EDGE_OFS = DEF_EDGE_OFS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mem_cmd,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       write_data,
  output logic [DATA_W-1:0]       read_data,
  input  logic [DATA_W-1:0]       ram_dout,
  output logic [ADDR_W-2:0]       ram_addr,
  output logic                    ram_write,
  input  logic [N_IN*DATA_W-1:0]  in_port,
  output logic [N_OUT*DATA_W-1:0] out_port,
  output logic [N_IN-1:0]         edge_flags,
  output logic                    bus_err
);

  logic                    ram_sel;
  logic                    io_sel;
  logic                    is_read;
  logic                    is_write;
  logic [ADDR_W-1:0]       offset;
  logic [N_OUT-1:0]        out_sel;
  logic [N_IN-1:0]         in_sel;
  logic                    edge_hit;
  logic                    mapped;
  logic                    access_err;
  logic [N_IN*DATA_W-1:0]  in_sync;
  logic [N_IN-1:0]         in_change;
  logic [N_OUT*DATA_W-1:0] out_q;
  logic [N_IN-1:0]         flags_q;
  logic                    err_q;

  assign ram_sel   = ~mem_addr[ADDR_W-1];
  assign io_sel    = mem_addr[ADDR_W-1];
  assign is_read   = (mem_cmd == MREAD);
  assign is_write  = (mem_cmd == MWRITE);
  assign offset    = mem_addr - IO_BASE;
  assign ram_write = is_write & ram_sel;
  assign ram_addr  = mem_addr[ADDR_W-2:0];

  always_comb begin
    out_sel = '0;
    in_sel  = '0;
    for (int i = 0; i < N_OUT; i++) out_sel[i] = io_sel && (offset == ADDR_W'(i));
    for (int j = 0; j < N_IN; j++)  in_sel[j]  = io_sel && (offset == ADDR_W'(IN_OFS + j));
  end

  assign edge_hit = io_sel && (offset == ADDR_W'(EDGE_OFS));
  assign mapped   = (|out_sel) | (|in_sel) | edge_hit;

  // Illegal accesses only raise the sticky flag; every write path below already excludes them
  assign access_err = (mem_cmd == MILLEGAL)
                    | (io_sel & (is_read | is_write) & ~mapped)
                    | (is_write & (|in_sel));

  always_comb begin
    read_data = '0;
    if (is_read) begin
      if (ram_sel) read_data = ram_dout;
      for (int i = 0; i < N_OUT; i++)
        if (out_sel[i]) read_data = out_q[i*DATA_W +: DATA_W];
      for (int j = 0; j < N_IN; j++)
        if (in_sel[j]) read_data = in_sync[j*DATA_W +: DATA_W];
      if (edge_hit) read_data = DATA_W'(flags_q);
    end
  end

  for (genvar j = 0; j < N_IN; j++) begin : g_in
    mmio_in_sync #(.DATA_W(DATA_W)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .din    (in_port[j*DATA_W +: DATA_W]),
      .dout   (in_sync[j*DATA_W +: DATA_W]),
      .change (in_change[j])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < N_OUT; i++)
        if (is_write && out_sel[i]) out_q[i*DATA_W +: DATA_W] <= write_data;
      // A fresh change pulse is OR'd in after the clear so a coincident set survives
      if (is_write && edge_hit) flags_q <= (flags_q & ~write_data[N_IN-1:0]) | in_change;
      else                      flags_q <= flags_q | in_change;
      if (access_err) err_q <= 1'b1;
    end
  end

  assign out_port   = out_q;
  assign edge_flags = flags_q;
  assign bus_err    = err_q;

endmodule

// File: tb/tb_mmio_bus.sv
// tb/tb_mmio_bus.sv - self-checking bench for mmio_bus against a behavioural address-map model
module tb_mmio_bus;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int NO = 2;
  localparam int NI = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic [DW-1:0] ram_dout;
  logic [AW-2:0] ram_addr;
  logic          ram_write;
  logic [NI*DW-1:0] in_port;
  logic [NO*DW-1:0] out_port;
  logic [NI-1:0] edge_flags;
  logic          bus_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  mmio_bus dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .ram_dout   (ram_dout),
    .ram_addr   (ram_addr),
    .ram_write  (ram_write),
    .in_port    (in_port),
    .out_port   (out_port),
    .edge_flags (edge_flags),
    .bus_err    (bus_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: address map as arithmetic, inputs as a history of per-edge samples
  logic [DW-1:0]    m_out [NO];
  logic [NI-1:0]    m_flags;
  logic             m_err;
  logic [NI*DW-1:0] samples [$];

  function automatic logic [NI*DW-1:0] ago(input int n);
    if (samples.size() > n) return samples[samples.size()-1-n];
    return '0;
  endfunction

  // 0 ram, 1 out, 2 in, 3 edge, 4 unmapped io
  function automatic int kind(input logic [AW-1:0] a);
    int off;
    if (a < 9'h100) return 0;
    off = int'(a) - 'h100;
    if (off < NO) return 1;
    if (off >= 'h40 && off < 'h40 + NI) return 2;
    if (off == 'h80) return 3;
    return 4;
  endfunction

  function automatic logic [DW-1:0] exp_rd();
    int off;
    logic [NI*DW-1:0] vis;
    off = int'(mem_addr) - 'h100;
    vis = ago(1);
    if (mem_cmd != 2'b01) return '0;
    case (kind(mem_addr))
      0: return ram_dout;
      1: return m_out[off];
      2: return vis[(off - 'h40)*DW +: DW];
      3: return DW'(m_flags);
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [NI*DW-1:0] a1;
    logic [NI*DW-1:0] a2;
    logic [NI-1:0]    nf;
    int k;
    int off;
    if (reset) begin
      for (int i = 0; i < NO; i++) m_out[i] = '0;
      m_flags = '0;
      m_err   = 1'b0;
      samples.delete();
    end else begin
      k   = kind(mem_addr);
      off = int'(mem_addr) - 'h100;
      a1  = ago(1);
      a2  = ago(2);
      for (int j = 0; j < NI; j++) begin
        nf[j] = m_flags[j] && !(mem_cmd == 2'b10 && k == 3 && write_data[j]);
        if (a1[j*DW +: DW] != a2[j*DW +: DW]) nf[j] = 1'b1;
      end
      if (mem_cmd == 2'b11 || (k == 4 && (mem_cmd == 2'b01 || mem_cmd == 2'b10))
          || (k == 2 && mem_cmd == 2'b10)) m_err = 1'b1;
      if (mem_cmd == 2'b10 && k == 1) m_out[off] = write_data;
      m_flags = nf;
      samples.push_back(in_port);
      if (samples.size() > 4) void'(samples.pop_front());
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("read_data", 64'(read_data), 64'(exp_rd()));
      chk("out_port", 64'(out_port), 64'({m_out[1], m_out[0]}));
      chk("edge_flags", 64'(edge_flags), 64'(m_flags));
      chk("bus_err", 64'(bus_err), 64'(m_err));
      chk("ram_write", 64'(ram_write), 64'(mem_cmd == 2'b10 && !mem_addr[AW-1]));
      chk("ram_addr", 64'(ram_addr), 64'(mem_addr[AW-2:0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setb(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_cmd    = c;
    mem_addr   = a;
    write_data = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    setb(2'b00, '0, '0);
    tick();
    reset = 1'b0;
  endtask

  logic [1:0]    ecmd  [3] = '{2'b10, 2'b01, 2'b11};
  logic [AW-1:0] eaddr [3] = '{9'h140, 9'h1FF, 9'h100};
  logic [AW-1:0] raddr [11] = '{9'h100, 9'h101, 9'h102, 9'h140, 9'h141, 9'h142,
                                9'h180, 9'h181, 9'h023, 9'h0FF, 9'h1FF};

  initial begin
    reset    = 1'b1;
    in_port  = '0;
    ram_dout = '0;
    setb(2'b00, '0, '0);
    tick();
    reset    = 1'b0;
    check_en = 1'b1;

    // Reset state
    chk("rst_out", 64'(out_port), 64'h0);
    chk("rst_flags", 64'(edge_flags), 64'h0);
    chk("rst_err", 64'(bus_err), 64'h0);
    setb(2'b01, 9'h100, '0);
    #2 chk("rst_rd100", 64'(read_data), 64'h0);

    // OUT write and readback
    setb(2'b10, 9'h100, 16'h00A5);
    tick();
    chk("out0", 64'(out_port[15:0]), 64'h00A5);
    setb(2'b10, 9'h101, 16'h1234);
    tick();
    chk("out01", 64'(out_port), 64'h1234_00A5);
    setb(2'b01, 9'h101, '0);
    #2 chk("rd101", 64'(read_data), 64'h1234);

    // Input synchroniser latency and change flag
    setb(2'b01, 9'h140, '0);
    in_port[15:0] = 16'h0033;
    #2 chk("in_0edge", 64'(read_data), 64'h0);
    tick();
    chk("in_1edge", 64'(read_data), 64'h0);
    tick();
    chk("in_2edge", 64'(read_data), 64'h0033);
    chk("flag_2edge", 64'(edge_flags), 64'h0);
    tick();
    chk("flag_3edge", 64'(edge_flags), 64'h1);

    // W1C and set-wins-over-clear
    in_port[31:16] = 16'h0007;
    repeat (3) tick();
    chk("flags11", 64'(edge_flags), 64'h3);
    setb(2'b10, 9'h180, 16'h0001);
    tick();
    chk("flags_clr0", 64'(edge_flags), 64'h2);
    setb(2'b00, '0, '0);
    in_port[31:16] = 16'h0008;
    tick();
    tick();
    setb(2'b10, 9'h180, 16'h0002);
    tick();
    chk("set_wins", 64'(edge_flags), 64'h2);
    tick();
    chk("flags_clr1", 64'(edge_flags), 64'h0);

    // Error cases, each from a fresh reset
    for (int e = 0; e < 3; e++) begin
      do_reset();
      setb(2'b10, 9'h100, 16'h5A5A);
      tick();
      setb(2'b00, '0, '0);
      #2 chk("err_pre", 64'(bus_err), 64'h0);
      setb(ecmd[e], eaddr[e], 16'hFFFF);
      #2 chk("err_rd0", 64'(read_data), 64'h0);
      tick();
      chk("err_set", 64'(bus_err), 64'h1);
      chk("err_out", 64'(out_port), 64'h0000_5A5A);
    end
    setb(2'b00, '0, '0);
    repeat (5) tick();
    chk("err_sticky", 64'(bus_err), 64'h1);
    do_reset();
    chk("err_rst", 64'(bus_err), 64'h0);

    // RAM passthrough
    setb(2'b10, 9'h023, 16'h7777);
    #2 chk("ram_we", 64'(ram_write), 64'h1);
    chk("ram_addr", 64'(ram_addr), 64'h23);
    tick();
    chk("ram_out", 64'(out_port), 64'h0);
    setb(2'b01, 9'h023, '0);
    ram_dout = 16'hBEEF;
    #2 chk("ram_rd", 64'(read_data), 64'hBEEF);
    chk("ram_we_rd", 64'(ram_write), 64'h0);

    // Reset overrides a coincident OUT write
    setb(2'b10, 9'h100, 16'h1111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    setb(2'b00, '0, '0);
    chk("rst_wr", 64'(out_port), 64'h0);

    // Mixed traffic checked cycle by cycle against the model
    for (int n = 0; n < 400; n++) begin
      logic [1:0] c;
      c = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      setb(c, raddr[$urandom_range(0, 10)], 16'($urandom));
      ram_dout = 16'($urandom);
      if ($urandom_range(0, 3) == 0) in_port[$urandom_range(0, NI-1)*DW +: DW] = 16'($urandom);
      reset = ($urandom_range(0, 49) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
